// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Frame deframer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Scan-code prefixes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_keyboard_if.sv
// Bundle of the PS/2 line pair and the receiver/decoder outputs.
interface ps2_keyboard_if #(
  parameter int wordsize = 32
);
  logic                ps2_clk;
  logic                ps2_data;
  logic [wordsize-1:0] keyb_char;
  logic [7:0]          rx_byte;
  logic                rx_strobe;
  logic                frame_err;

  // Keyboard side: drives the PS/2 lines, observes the decoded outputs
  modport master (
    output ps2_clk, ps2_data,
    input  keyb_char, rx_byte, rx_strobe, frame_err
  );

  // Receiver side
  modport slave (
    input  ps2_clk, ps2_data,
    output keyb_char, rx_byte, rx_strobe, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizer, falling-edge detect, 11-bit deframer
// with odd-parity/stop checking and an inter-edge timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic            clk_s1, clk_s2, clk_s3;
  logic            data_s1, data_s2;
  logic            fall;

  ps2_state_t      state_reg, state_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic            parity_reg, parity_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [7:0]      byte_next;
  logic            strobe_next, err_next;

  // Two-flop synchronizers (idle-high lines reset to 1) plus an edge flop on clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fall = ~clk_s2 & clk_s3;

  // Frame state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tmo_reg     <= '0;
      rx_byte     <= '0;
      rx_strobe   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      tmo_reg     <= tmo_next;
      rx_byte     <= byte_next;
      rx_strobe   <= strobe_next;
      frame_err   <= err_next;
    end
  end

  // Next-state logic: advances on PS/2 falling edges, otherwise watches the timeout
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    tmo_next     = '0;
    byte_next    = rx_byte;
    strobe_next  = 1'b0;
    err_next     = 1'b0;

    if (state_reg != IDLE) begin
      tmo_next = fall ? '0 : tmo_reg + 1'b1;
    end

    if (fall) begin
      unique case (state_reg)
        IDLE: begin
          if (!data_s2) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next = {data_s2, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        PARITY: begin
          parity_next = data_s2;
          state_next  = STOP;
        end
        STOP: begin
          // Odd parity over data+parity and a high stop bit make a good frame
          if (data_s2 && (^{shift_reg, parity_reg})) begin
            byte_next   = shift_reg;
            strobe_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && tmo_reg == TW'(TIMEOUT)) begin
      // Keyboard stopped clocking mid-frame: drop the partial byte
      state_next   = IDLE;
      err_next     = 1'b1;
      tmo_next     = '0;
      bit_cnt_next = '0;
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver and scan-code decoder. Holds {ext, code} of the
// currently pressed key in keyb_char, or 0 when no key is held.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int wordsize = 32,
  parameter int TIMEOUT  = 10000
) (
  input  logic                clk,
  input  logic                reset,
  ps2_keyboard_if.slave       bus
);

  logic                ext_reg, ext_next;
  logic                brk_reg, brk_next;
  logic [wordsize-1:0] char_reg, char_next;

  ps2_rx #(
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .rx_byte   (bus.rx_byte),
    .rx_strobe (bus.rx_strobe),
    .frame_err (bus.frame_err)
  );

  // Decoder registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_reg  <= 1'b0;
      brk_reg  <= 1'b0;
      char_reg <= '0;
    end else begin
      ext_reg  <= ext_next;
      brk_reg  <= brk_next;
      char_reg <= char_next;
    end
  end

  // Prefix tracking and make/break handling on each received byte
  always_comb begin
    ext_next  = ext_reg;
    brk_next  = brk_reg;
    char_next = char_reg;
    if (bus.rx_strobe) begin
      if (bus.rx_byte == PS2_EXT) begin
        ext_next = 1'b1;
      end else if (bus.rx_byte == PS2_BRK) begin
        brk_next = 1'b1;
      end else if (brk_reg) begin
        // Only releasing the held key clears it; other releases are ignored
        if ({ext_reg, bus.rx_byte} == char_reg[8:0]) begin
          char_next = '0;
        end
        brk_next = 1'b0;
        ext_next = 1'b0;
      end else begin
        char_next = {{(wordsize-9){1'b0}}, ext_reg, bus.rx_byte};
        ext_next  = 1'b0;
      end
    end
  end

  assign bus.keyb_char = char_reg;

endmodule
